fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_mult_pipe_if.sv | 37 +++
 rtl/fp_classify.sv | 33 +++
 rtl/fp_mult_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared types for the pipelined floating-point multiplier: default widths,
// rounding modes, operand classes and the exception flag bundle.
package fp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int TAG_W_DEF = 8;

  typedef enum logic {
    RND_RNE = 1'b0,
    RND_RTZ = 1'b1
  } rnd_mode_e;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic nan;
    logic inexact;
  } fp_flags_t;

  // Class of a product given the classes of its two operands.
  function automatic fp_class_e product_class(input fp_class_e a, input fp_class_e b);
    if (a == NAN || b == NAN || (a == INF && b == ZERO) || (a == ZERO && b == INF))
      return NAN;
    if (a == INF || b == INF)
      return INF;
    if (a == ZERO || b == ZERO)
      return ZERO;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe; the producer/consumer side
// uses the master modport, the multiplier uses the slave modport.
interface fp_mult_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     dataa;
  logic [W-1:0]     datab;
  logic [TAG_W-1:0] in_tag;
  logic             rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic             overflow;
  logic             underflow;
  logic             nan;
  logic             inexact;

  modport master (
    output in_valid, dataa, datab, in_tag, rnd_mode, out_ready,
    input  in_ready, out_valid, result, out_tag, overflow, underflow, nan, inexact
  );

  modport slave (
    input  in_valid, dataa, datab, in_tag, rnd_mode, out_ready,
    output in_ready, out_valid, result, out_tag, overflow, underflow, nan, inexact
  );

endinterface

// File: rtl/fp_classify.sv
// Splits one operand into sign/exponent/mantissa (hidden bit restored) and
// classifies it; subnormals are reported as ZERO.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_field,
  output logic [MAN_W:0]       man,
  output fp_class_e            cls
);

  logic [MAN_W-1:0] frac;

  assign sign      = op[EXP_W+MAN_W];
  assign exp_field = op[MAN_W +: EXP_W];
  assign frac      = op[MAN_W-1:0];
  assign man       = {1'b1, frac};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/case can leave it unassigned and infer a latch.
  always_comb begin
    cls = NORMAL;
    if (exp_field == '0)
      cls = ZERO;
    else if (exp_field == '1)
      cls = (frac == '0) ? INF : NAN;
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Four-stage floating-point multiplier: S1 unpack/classify, S2 mantissa
// multiply, S3 normalise, S4 round/pack/flags, with a stall-able handshake.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clk_en,
  fp_mult_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  logic s1_valid, s2_valid, s3_valid, s4_valid;

  // Operand unpack
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  fp_class_e        a_cls, b_cls;

  // S1 registers
  logic [TAG_W-1:0] s1_tag;
  rnd_mode_e        s1_rnd;
  logic             s1_sign;
  fp_class_e        s1_cls;
  logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
  logic [MAN_W:0]   s1_man_a, s1_man_b;

  // S2 registers
  logic [TAG_W-1:0]     s2_tag;
  rnd_mode_e            s2_rnd;
  logic                 s2_sign;
  fp_class_e            s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  // S3 registers
  logic [TAG_W-1:0]     s3_tag;
  rnd_mode_e            s3_rnd;
  logic                 s3_sign;
  fp_class_e            s3_cls;
  logic signed [EW-1:0] s3_exp;
  logic [MAN_W:0]       s3_man;
  logic                 s3_guard;
  logic                 s3_sticky;

  // S4 registers (the visible outputs)
  logic [W-1:0]     s4_result;
  logic [TAG_W-1:0] s4_tag;
  fp_flags_t        s4_flags;

  // Combinational stage logic
  logic [PW-1:0]        prod_c;
  logic signed [EW-1:0] exp_sum_c;
  logic [PW-1:0]        norm_c;
  logic signed [EW-1:0] norm_exp_c;
  logic                 round_up;
  logic [MW:0]          man_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic [MAN_W-1:0]     frac_rnd;
  logic                 lost;
  logic [W-1:0]         res_c;
  fp_flags_t            flags_c;

  assign advance      = clk_en && (!s4_valid || bus.out_ready);
  assign bus.in_ready = advance && !reset;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op        (bus.dataa),
    .sign      (a_sign),
    .exp_field (a_exp),
    .man       (a_man),
    .cls       (a_cls)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op        (bus.datab),
    .sign      (b_sign),
    .exp_field (b_exp),
    .man       (b_man),
    .cls       (b_cls)
  );

  // S2: full-width mantissa product and unbiased exponent sum.
  assign prod_c    = PW'(s1_man_a) * PW'(s1_man_b);
  assign exp_sum_c = $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS;

  // S3: the product lies in [1,4), so at most one bit of normalisation.
  assign norm_c     = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
  assign norm_exp_c = s2_exp + $signed({{(EW-1){1'b0}}, s2_prod[PW-1]});

  // S4: round, pack and raise flags.
  always_comb begin
    round_up = (s3_rnd == RND_RNE) && s3_guard && (s3_sticky || s3_man[0]);
    man_rnd  = {1'b0, s3_man} + {{MW{1'b0}}, round_up};
    exp_rnd  = s3_exp + $signed({{(EW-1){1'b0}}, man_rnd[MW]});
    frac_rnd = man_rnd[MW] ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];
    lost     = s3_guard || s3_sticky;
    res_c    = '0;
    flags_c  = '0;
    case (s3_cls)
      NAN: begin
        res_c       = QNAN;
        flags_c.nan = 1'b1;
      end
      INF:  res_c = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: res_c = {s3_sign, {(W-1){1'b0}}};
      default: begin
        if (exp_rnd >= EXP_TOP) begin
          flags_c.overflow = 1'b1;
          flags_c.inexact  = 1'b1;
          res_c = (s3_rnd == RND_RTZ) ? {s3_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                      : {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_rnd <= EXP_ZERO) begin
          flags_c.underflow = 1'b1;
          flags_c.inexact   = 1'b1;
          res_c = {s3_sign, {(W-1){1'b0}}};
        end else begin
          flags_c.inexact = lost;
          res_c = {s3_sign, exp_rnd[EXP_W-1:0], frac_rnd};
        end
      end
    endcase
  end

  // Valid chain and visible outputs are cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s4_valid  <= 1'b0;
      s4_result <= '0;
      s4_tag    <= '0;
      s4_flags  <= '0;
    end else if (advance) begin
      s1_valid  <= bus.in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      s4_valid  <= s3_valid;
      s4_result <= res_c;
      s4_tag    <= s3_tag;
      s4_flags  <= flags_c;
    end
  end

  // NOTE: internal datapath registers carry no reset; a slot is only ever
  // observed through its valid bit, which is reset, so stale data is harmless.
  always_ff @(posedge clock) begin
    if (advance) begin
      s1_tag    <= bus.in_tag;
      s1_rnd    <= rnd_mode_e'(bus.rnd_mode);
      s1_sign   <= a_sign ^ b_sign;
      s1_cls    <= product_class(a_cls, b_cls);
      s1_exp_a  <= a_exp;
      s1_exp_b  <= b_exp;
      s1_man_a  <= a_man;
      s1_man_b  <= b_man;

      s2_tag    <= s1_tag;
      s2_rnd    <= s1_rnd;
      s2_sign   <= s1_sign;
      s2_cls    <= s1_cls;
      s2_exp    <= exp_sum_c;
      s2_prod   <= prod_c;

      s3_tag    <= s2_tag;
      s3_rnd    <= s2_rnd;
      s3_sign   <= s2_sign;
      s3_cls    <= s2_cls;
      s3_exp    <= norm_exp_c;
      s3_man    <= norm_c[PW-1 -: MW];
      s3_guard  <= norm_c[PW-MW-1];
      s3_sticky <= |norm_c[PW-MW-2:0];
    end
  end

  assign bus.out_valid = s4_valid;
  assign bus.result    = s4_result;
  assign bus.out_tag   = s4_tag;
  assign bus.overflow  = s4_flags.overflow;
  assign bus.underflow = s4_flags.underflow;
  assign bus.nan       = s4_flags.nan;
  assign bus.inexact   = s4_flags.inexact;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe at half precision: directed vectors are
// queued on acceptance and a monitor compares each delivered result in order.
module tb_fp_mult_pipe;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_OV   = 4'b1000;
  localparam logic [3:0] F_UF   = 4'b0100;
  localparam logic [3:0] F_NAN  = 4'b0010;
  localparam logic [3:0] F_IX   = 4'b0001;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  tag;
    logic [3:0]  fl;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic clk_en;

  int   checks = 0;
  int   errors = 0;
  int   tg     = 0;
  exp_t sb[$];
  exp_t mon_e;

  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(8)) bus ();

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Present one operand pair from posedge+1; queue its expectation on acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                       input logic rnd, input logic [15:0] res, input logic [3:0] fl);
    exp_t e;
    bit   acc = 1'b0;
    int   n   = 0;
    bus.dataa    = a;
    bus.datab    = b;
    bus.in_tag   = tag;
    bus.rnd_mode = rnd;
    bus.in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clock);
      if (bus.in_ready) begin
        acc   = 1'b1;
        e.res = res;
        e.tag = tag;
        e.fl  = fl;
        sb.push_back(e);
      end
      @(posedge clock);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: tag %0d never accepted", tag);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                    input logic [15:0] res, input logic [3:0] fl);
    tg = tg + 1;
    issue(a, b, 8'(tg), rnd, res, fl);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: a result transfers on the edge following a negedge where it is offered and taken.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && clk_en && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result=%h tag=%0d", bus.result, bus.out_tag);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("result tag%0d", mon_e.tag), 32'(bus.result), 32'(mon_e.res));
          check($sformatf("out_tag tag%0d", mon_e.tag), 32'(bus.out_tag), 32'(mon_e.tag));
          check($sformatf("flags tag%0d", mon_e.tag),
                32'({bus.overflow, bus.underflow, bus.nan, bus.inexact}), 32'(mon_e.fl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    clk_en        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dataa     = '0;
    bus.datab     = '0;
    bus.in_tag    = '0;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_out_tag", 32'(bus.out_tag), 0);
    check("rst_flags", 32'({bus.overflow, bus.underflow, bus.nan, bus.inexact}), 0);
    clk_en = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clock);
    #1;

    // Latency on an empty pipeline
    op(16'h3C00, 16'h4000, 1'b0, 16'h4000, F_NONE);
    repeat (3) @(negedge clock);
    check("latency_early", 32'(bus.out_valid), 0);
    @(negedge clock);
    check("latency_on_time", 32'(bus.out_valid), 1);
    drain();

    // Back-to-back directed vectors
    op(16'h3C01, 16'h3C01, 1'b0, 16'h3C02, F_IX);
    op(16'h3C01, 16'h3C01, 1'b1, 16'h3C02, F_IX);
    op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, F_OV | F_IX);
    op(16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, F_OV | F_IX);
    op(16'h7C00, 16'h0000, 1'b0, 16'h7E00, F_NAN);
    op(16'h0000, 16'h7C00, 1'b1, 16'h7E00, F_NAN);
    op(16'h0400, 16'h0400, 1'b0, 16'h0000, F_UF | F_IX);
    op(16'h7C00, 16'hC000, 1'b0, 16'hFC00, F_NONE);
    op(16'h8000, 16'h3C00, 1'b0, 16'h8000, F_NONE);
    op(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, F_NAN);
    op(16'h7C01, 16'h0000, 1'b1, 16'h7E00, F_NAN);
    op(16'h0001, 16'h3C00, 1'b0, 16'h0000, F_NONE);
    op(16'hC200, 16'h4100, 1'b0, 16'hC780, F_NONE);
    op(16'h3C01, 16'h3E00, 1'b0, 16'h3E02, F_IX);
    op(16'h3C01, 16'h3E00, 1'b1, 16'h3E01, F_IX);
    op(16'h3C03, 16'h3E00, 1'b0, 16'h3E04, F_IX);
    op(16'h3DA8, 16'h3DA8, 1'b0, 16'h4000, F_IX);
    op(16'h3DA8, 16'h3DA8, 1'b1, 16'h3FFF, F_IX);
    op(16'h79A8, 16'h3DA8, 1'b0, 16'h7C00, F_OV | F_IX);
    op(16'h79A8, 16'h3DA8, 1'b1, 16'h7BFF, F_IX);
    op(16'h0400, 16'h3C00, 1'b0, 16'h0400, F_NONE);
    op(16'h8400, 16'h3800, 1'b0, 16'h8000, F_UF | F_IX);
    op(16'hFC00, 16'hFC00, 1'b1, 16'h7C00, F_NONE);
    drain();

    // clk_en low freezes a held result even while the consumer is ready
    bus.out_ready = 1'b0;
    op(16'h4200, 16'h4200, 1'b0, 16'h4880, F_NONE);
    repeat (4) @(negedge clock);
    check("freeze_pre_valid", 32'(bus.out_valid), 1);
    @(posedge clock);
    #1;
    clk_en        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("freeze_in_ready", 32'(bus.in_ready), 0);
      check("freeze_result", 32'(bus.result), 32'h4880);
    end
    @(posedge clock);
    #1;
    clk_en = 1'b1;
    drain();

    // Six tagged ops against a consumer stalled for 8 cycles
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++)
          issue(16'h3DA8, 16'h3DA8, 8'(k), k[0], (k[0] ? 16'h3FFF : 16'h4000), F_IX);
      end
      begin
        repeat (6) @(negedge clock);
        check("stall_in_ready", 32'(bus.in_ready), 0);
        check("stall_out_valid", 32'(bus.out_valid), 1);
        check("stall_out_tag", 32'(bus.out_tag), 1);
        repeat (2) @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight discards them all
    bus.out_ready = 1'b0;
    issue(16'h3C00, 16'h4000, 8'h21, 1'b0, 16'h4000, F_NONE);
    issue(16'h3C01, 16'h3C01, 8'h22, 1'b0, 16'h3C02, F_IX);
    issue(16'h7BFF, 16'h7BFF, 8'h23, 1'b0, 16'h7C00, F_OV | F_IX);
    @(posedge clock);
    #1;
    check("inflight_valid", 32'(bus.out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    check("midrst_result", 32'(bus.result), 0);
    check("midrst_out_tag", 32'(bus.out_tag), 0);
    check("midrst_flags", 32'({bus.overflow, bus.underflow, bus.nan, bus.inexact}), 0);
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #3;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rerst_in_ready", 32'(bus.in_ready), 1);
    repeat (10) @(negedge clock);
    check("no_stale_valid", 32'(bus.out_valid), 0);
    @(posedge clock);
    #1;
    op(16'h4200, 16'hC200, 1'b0, 16'hC880, F_NONE);
    drain();

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
